// File: rtl/alu_seq_pkg.sv
// ============================================================================
// alu_seq_pkg : opcodes, FSM state type and width helper for alu_seq
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_PASSA = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int shamt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_comb.sv
// ============================================================================
// alu_seq_comb : single-cycle datapath (add/sub, logic, compares, PASSA)
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  // Subtract as A + ~B + 1 so the top bit is the not-borrow flag directly.
  assign w_sum  = {1'b0, a_i} + {1'b0, b_i};
  assign w_diff = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    res_o   = '0;
    carry_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        res_o   = w_sum[WIDTH-1:0];
        carry_o = w_sum[WIDTH];
      end
      OP_SUB: begin
        res_o   = w_diff[WIDTH-1:0];
        carry_o = w_diff[WIDTH];
      end
      OP_AND:   res_o = a_i & b_i;
      OP_OR:    res_o = a_i | b_i;
      OP_XOR:   res_o = a_i ^ b_i;
      OP_SLT:   res_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU:  res_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      OP_PASSA: res_o = a_i;
      default: begin
        res_o   = '0;
        carry_o = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq : sequential ALU with operand latches, iterative shift/multiply
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic [WIDTH-1:0] pass_i,
  input  logic             load_a_i,
  input  logic             load_b_i,
  input  logic             load_pass_i,
  input  logic [3:0]       op_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] res_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             zero_o,
  output logic             carry_o,
  output logic [WIDTH-1:0] pass_o
);

  localparam int SHAMT_W = shamt_w(WIDTH);
  localparam logic [SHAMT_W-1:0] c_cnt_one = SHAMT_W'(1);
  localparam logic [SHAMT_W-1:0] c_mul_cnt = SHAMT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, pass_q;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [3:0]         op_q, op_d;
  logic               carry_q, carry_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0]   w_comb_res;
  logic               w_comb_carry;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_is_shift;

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i     (a_q),
    .b_i     (b_q),
    .op_i    (op_i),
    .res_o   (w_comb_res),
    .carry_o (w_comb_carry)
  );

  assign w_shamt    = b_q[SHAMT_W-1:0];
  assign w_is_shift = (op_i == OP_SLL) || (op_i == OP_SRL) || (op_i == OP_SRA);

  function automatic logic [WIDTH-1:0] shift1(input logic [3:0] op, input logic [WIDTH-1:0] x);
    case (op)
      OP_SLL:  return {x[WIDTH-2:0], 1'b0};
      OP_SRL:  return {1'b0, x[WIDTH-1:1]};
      default: return {x[WIDTH-1], x[WIDTH-1:1]};
    endcase
  endfunction

  // The first shift / multiplier step happens on the start edge so that a
  // result needing N steps is valid exactly N cycles after start.
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    carry_d  = carry_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          carry_d = 1'b0;
          state_d = ST_DONE;
          if (w_is_shift) begin
            if (w_shamt == '0) begin
              res_d = a_q;
            end else begin
              res_d = shift1(op_i, a_q);
              cnt_d = w_shamt - c_cnt_one;
              if (w_shamt != c_cnt_one) state_d = ST_SHIFT;
            end
          end else if ((op_i == OP_MUL) && MUL_EN) begin
            res_d    = b_q[0] ? a_q : '0;
            mcand_d  = {a_q[WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, b_q[WIDTH-1:1]};
            cnt_d    = c_mul_cnt;
            state_d  = ST_MUL;
          end else begin
            res_d   = w_comb_res;
            carry_d = w_comb_carry;
          end
        end
      end
      ST_SHIFT: begin
        res_d = shift1(op_q, res_q);
        cnt_d = cnt_q - c_cnt_one;
        if (cnt_q == c_cnt_one) state_d = ST_DONE;
      end
      ST_MUL: begin
        if (mplier_q[0]) res_d = res_q + mcand_q;
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - c_cnt_one;
        if (cnt_q == c_cnt_one) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      pass_q   <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      // Operands stay frozen for the whole operation and while a result waits.
      if (state_q == ST_IDLE) begin
        if (load_a_i)    a_q    <= opa_i;
        if (load_b_i)    b_q    <= opb_i;
        if (load_pass_i) pass_q <= pass_i;
      end
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign res_valid_o = (state_q == ST_DONE);
  assign res_o       = res_valid_o ? res_q : '0;
  assign zero_o      = res_valid_o && (res_q == '0);
  assign carry_o     = res_valid_o && carry_q;
  assign pass_o      = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// tb_alu_seq : directed scoreboard bench for alu_seq (MUL_EN=1 and MUL_EN=0)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq;
  import alu_seq_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        carry;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] opa_i, opb_i, pass_i;
  logic        load_a_i, load_b_i, load_pass_i;
  logic [3:0]  op_i;
  logic        start_i, res_ready_i;
  logic        busy_o, res_valid_o, zero_o, carry_o;
  logic [31:0] res_o, pass_o;

  logic        start0_i, ready0_i;
  logic        busy0_o, valid0_o, zero0_o, carry0_o;
  logic [31:0] res0_o, pass0_o;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .opa_i(opa_i), .opb_i(opb_i), .pass_i(pass_i),
    .load_a_i(load_a_i), .load_b_i(load_b_i), .load_pass_i(load_pass_i),
    .op_i(op_i), .start_i(start_i), .busy_o(busy_o), .res_o(res_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .zero_o(zero_o),
    .carry_o(carry_o), .pass_o(pass_o)
  );

  alu_seq #(.WIDTH(32), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .opa_i(opa_i), .opb_i(opb_i), .pass_i(pass_i),
    .load_a_i(load_a_i), .load_b_i(load_b_i), .load_pass_i(load_pass_i),
    .op_i(op_i), .start_i(start0_i), .busy_o(busy0_o), .res_o(res0_o),
    .res_valid_o(valid0_o), .res_ready_i(ready0_i), .zero_o(zero0_o),
    .carry_o(carry0_o), .pass_o(pass0_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    opa_i = a; opb_i = b; load_a_i = 1'b1; load_b_i = 1'b1;
    @(negedge clk);
    load_a_i = 1'b0; load_b_i = 1'b0;
  endtask

  // Drive one operation, push its expectation, then pop and compare on valid.
  task automatic run(input logic [3:0] op, input logic [31:0] er, input logic ec,
                     input int elat, input int hold, input bit disturb,
                     input bit simload, input logic [31:0] simval);
    exp_t e;
    int   cyc;
    @(negedge clk);
    op_i = op; start_i = 1'b1;
    if (simload) begin opa_i = simval; load_a_i = 1'b1; end
    sb.push_back('{res: er, carry: ec, lat: elat});
    @(negedge clk);
    start_i = 1'b0; load_a_i = 1'b0; cyc = 1;
    while (!res_valid_o && cyc < 100) begin
      if (disturb && cyc == 2) begin
        start_i = 1'b1; load_a_i = 1'b1; opa_i = 32'hDEAD_BEEF; op_i = OP_ADD;
      end
      @(negedge clk);
      start_i = 1'b0; load_a_i = 1'b0; cyc++;
    end
    e = sb.pop_front();
    chk("valid", res_valid_o, 1);
    chk("latency", cyc, e.lat);
    chk("res", res_o, e.res);
    chk("zero", zero_o, (e.res == 32'h0));
    chk("carry", carry_o, e.carry);
    chk("busy_done", busy_o, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", res_valid_o, 1);
      chk("hold_res", res_o, e.res);
      chk("hold_flags", {zero_o, carry_o}, {(e.res == 32'h0), e.carry});
    end
    res_ready_i = 1'b1;
    if (disturb) begin
      start_i = 1'b1; load_a_i = 1'b1; opa_i = 32'hDEAD_BEEF; op_i = OP_ADD;
    end
    @(negedge clk);
    res_ready_i = 1'b0; start_i = 1'b0; load_a_i = 1'b0;
    chk("valid_drop", res_valid_o, 0);
    chk("idle_after", busy_o, 0);
  endtask

  initial begin
    int seen;
    reset = 1'b1; opa_i = '0; opb_i = '0; pass_i = '0;
    load_a_i = 0; load_b_i = 0; load_pass_i = 0; op_i = '0;
    start_i = 0; res_ready_i = 0; start0_i = 0; ready0_i = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {busy_o, res_valid_o, zero_o, carry_o}, 4'b0000);
    chk("rst_res", res_o, 0);
    chk("rst_pass", pass_o, 0);

    pass_i = 32'h0000_CAFE; load_pass_i = 1'b1;
    @(negedge clk);
    load_pass_i = 1'b0;
    chk("pass_load", pass_o, 32'h0000_CAFE);

    // Add with wrap-around and backpressure
    load(32'hFFFF_FFFF, 32'h1);
    run(OP_ADD, 32'h0, 1'b1, 1, 5, 0, 0, 0);

    load(32'h5, 32'h7);
    run(OP_SUB, 32'hFFFF_FFFE, 1'b0, 1, 0, 0, 0, 0);
    load(32'h7, 32'h5);
    run(OP_SUB, 32'h2, 1'b1, 1, 0, 0, 0, 0);

    load(32'hF0F0_00FF, 32'h0FF0_0F0F);
    run(OP_AND, 32'h00F0_000F, 1'b0, 1, 0, 0, 0, 0);
    run(OP_OR,  32'hFFF0_0FFF, 1'b0, 1, 0, 0, 0, 0);
    run(OP_XOR, 32'hFF00_0FF0, 1'b0, 1, 0, 0, 0, 0);

    load(32'h8000_0000, 32'h1);
    run(OP_SLT,   32'h1, 1'b0, 1, 0, 0, 0, 0);
    run(OP_SLTU,  32'h0, 1'b0, 1, 0, 0, 0, 0);
    run(OP_PASSA, 32'h8000_0000, 1'b0, 1, 0, 0, 0, 0);
    run(4'd12, 32'h0, 1'b0, 1, 0, 0, 0, 0);

    // Iterative shifts
    load(32'h8000_0000, 32'h4);
    run(OP_SRA, 32'hF800_0000, 1'b0, 4, 0, 0, 0, 0);
    run(OP_SRL, 32'h0800_0000, 1'b0, 4, 0, 0, 0, 0);
    run(OP_SLL, 32'h0, 1'b0, 4, 0, 0, 0, 0);
    load(32'h8000_0000, 32'h0);
    run(OP_SRA, 32'h8000_0000, 1'b0, 1, 0, 0, 0, 0);
    load(32'h3, 32'h25);
    run(OP_SLL, 32'h60, 1'b0, 5, 0, 0, 0, 0);

    // Multiply, then the MUL_EN=0 instance on the same operands
    load(32'h0001_0000, 32'h0001_0001);
    run(OP_MUL, 32'h0001_0000, 1'b0, 32, 0, 0, 0, 0);
    @(negedge clk);
    op_i = OP_MUL; start0_i = 1'b1;
    @(negedge clk);
    start0_i = 1'b0;
    chk("mul0_valid", valid0_o, 1);
    chk("mul0_res", res0_o, 0);
    chk("mul0_flags", {zero0_o, carry0_o}, 2'b10);
    @(negedge clk);
    chk("mul0_idle", busy0_o, 0);

    // Start/load pulses while busy and in DONE are ignored
    run(OP_MUL, 32'h0001_0000, 1'b0, 32, 2, 1, 0, 0);
    run(OP_ADD, 32'h0002_0001, 1'b0, 1, 0, 0, 0, 0);

    // Load coinciding with start uses the old A
    load(32'h2, 32'h3);
    run(OP_ADD, 32'h5, 1'b0, 1, 0, 0, 1, 32'h9);
    run(OP_ADD, 32'hC, 1'b0, 1, 0, 0, 0, 0);

    // Reset mid-multiply: no result ever appears
    load(32'h0001_0000, 32'h0001_0001);
    @(negedge clk);
    op_i = OP_MUL; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("mul_busy", busy_o, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid_o || busy_o) seen++;
    end
    chk("abort_no_valid", seen, 0);
    chk("abort_outputs", {busy_o, res_valid_o, zero_o, carry_o}, 4'b0000);
    chk("abort_res", res_o, 0);
    chk("abort_pass", pass_o, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
